push_counter_ctrl: RTL



---
 rtl/push_counter_ctrl_pkg.sv | 22 ++
 rtl/push_counter_ctrl_press_classifier.sv | 85 ++++++++
 rtl/push_counter_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/push_counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : push_counter_ctrl_pkg
// Brief    : Shared state encodings and default sizing for the push counter.
// Revision : 1.0 - initial release
// ============================================================================
package push_counter_ctrl_pkg;

    localparam int CNT_W_DEF      = 4;
    localparam int TERMINAL_DEF   = 15;
    localparam int LONG_PRESS_DEF = 48000;
    localparam int HOLD_W_DEF     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/push_counter_ctrl_press_classifier.sv
`default_nettype none
// ============================================================================
// Module   : push_counter_ctrl_press_classifier
// Brief    : Synchronises the button and classifies each press as short/long.
// Revision : 1.0 - initial release
// ============================================================================
module push_counter_ctrl_press_classifier
    import push_counter_ctrl_pkg::*;
#(
    parameter int LONG_PRESS = LONG_PRESS_DEF,
    parameter int HOLD_W     = HOLD_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_evt_short,
    output logic o_evt_long
);

    localparam logic [HOLD_W-1:0] c_HOLD_MAX = {HOLD_W{1'b1}};
    localparam logic [HOLD_W-1:0] c_LONG_M1  = HOLD_W'(LONG_PRESS - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_ONE = HOLD_W'(1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_btn_d;
    logic [1:0]        r_vld;
    logic              r_armed;
    logic              r_long;
    logic [HOLD_W-1:0] r_hold;
    logic              r_evt_short;
    logic              r_evt_long;

    logic w_lvl;
    logic w_held;
    logic w_rise;
    logic w_long;

    // Until an idle (high) level has been seen after reset, a held button is
    // treated as released so a press spanning reset never produces an event.
    assign w_lvl  = r_sync2 | ~r_armed;
    assign w_held = ~r_btn_d;
    assign w_rise = w_lvl & ~r_btn_d;
    assign w_long = w_held & ~r_long & (r_hold == c_LONG_M1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_btn_d     <= 1'b1;
            r_vld       <= 2'b00;
            r_armed     <= 1'b0;
            r_long      <= 1'b0;
            r_hold      <= '0;
            r_evt_short <= 1'b0;
            r_evt_long  <= 1'b0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            if (r_vld[1] && r_sync2) begin
                r_armed <= 1'b1;
            end
            r_btn_d     <= w_lvl;
            r_evt_long  <= w_long;
            r_evt_short <= w_rise & ~r_long & ~w_long;
            if (w_rise) begin
                r_hold <= '0;
                r_long <= 1'b0;
            end else begin
                if (w_held && (r_hold != c_HOLD_MAX)) begin
                    r_hold <= r_hold + c_HOLD_ONE;
                end
                if (w_long) begin
                    r_long <= 1'b1;
                end
            end
        end
    end

    assign o_evt_short = r_evt_short;
    assign o_evt_long  = r_evt_long;

endmodule
`default_nettype wire

// File: rtl/push_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : push_counter_ctrl
// Brief    : Run controller: press commands plus tick counting to TERMINAL.
// Revision : 1.0 - initial release
// ============================================================================
module push_counter_ctrl
    import push_counter_ctrl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int TERMINAL   = TERMINAL_DEF,
    parameter int LONG_PRESS = LONG_PRESS_DEF,
    parameter int HOLD_W     = HOLD_W_DEF,
    parameter int AUTO_STOP  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_btn_n,
    input  logic             i_tick,
    output logic [CNT_W-1:0] o_count,
    output logic [1:0]       o_state,
    output logic             o_run,
    output logic             o_done,
    output logic             o_clr
);

    localparam bit             c_TERM_EN = (TERMINAL != 0);
    localparam bit             c_AUTO    = (AUTO_STOP != 0);
    localparam logic [CNT_W-1:0] c_TERM    = CNT_W'(TERMINAL);
    localparam logic [CNT_W-1:0] c_TERM_M1 = CNT_W'((TERMINAL > 0) ? (TERMINAL - 1) : 0);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_run;
    logic             r_done;
    logic             r_clr;

    logic             w_evt_short;
    logic             w_evt_long;
    logic             w_tick_run;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_done_nxt;
    logic             w_clr_nxt;

    push_counter_ctrl_press_classifier #(
        .LONG_PRESS (LONG_PRESS),
        .HOLD_W     (HOLD_W)
    ) u_press (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_btn_n     (i_btn_n),
        .o_evt_short (w_evt_short),
        .o_evt_long  (w_evt_long)
    );

    assign w_tick_run = i_tick & (r_state == ST_RUN);

    // A long press overrides everything; otherwise the tick is applied first so
    // that a completion in the same cycle as a short press ends in DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        w_clr_nxt   = 1'b0;
        if (w_evt_long) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
            w_clr_nxt   = 1'b1;
        end else begin
            if (w_tick_run) begin
                if (c_TERM_EN && (r_count == c_TERM_M1)) begin
                    w_count_nxt = c_TERM;
                    w_done_nxt  = 1'b1;
                    if (c_AUTO) begin
                        w_state_nxt = ST_DONE;
                    end
                end else if (!c_AUTO && c_TERM_EN && (r_count == c_TERM)) begin
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + c_ONE;
                end
            end
            if (w_evt_short) begin
                case (r_state)
                    ST_IDLE:  w_state_nxt = ST_RUN;
                    ST_RUN: begin
                        if (w_state_nxt != ST_DONE) begin
                            w_state_nxt = ST_PAUSE;
                        end
                    end
                    ST_PAUSE: w_state_nxt = ST_RUN;
                    ST_DONE: begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = '0;
                        w_clr_nxt   = 1'b1;
                    end
                    default:  w_state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_run   <= 1'b0;
            r_done  <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_run   <= (w_state_nxt == ST_RUN);
            r_done  <= w_done_nxt;
            r_clr   <= w_clr_nxt;
        end
    end

    assign o_count = r_count;
    assign o_state = r_state;
    assign o_run   = r_run;
    assign o_done  = r_done;
    assign o_clr   = r_clr;

endmodule
`default_nettype wire
